// File: rtl/casez_classifier_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// casez_classifier_if
// Bundles the configuration write port and the two valid/ready streams of the
// pattern classifier.
//   cfg_we/cfg_idx/cfg_val/cfg_care/cfg_code/cfg_en : table entry write
//   in_valid/in_ready/in_data                       : words to classify
//   out_valid/out_ready/out_code/out_hit/out_multi  : registered results
// master = the side that drives words and configuration (e.g. a testbench),
// slave  = the classifier itself.
// -----------------------------------------------------------------------------
interface casez_classifier_if #(
  parameter int UW   = 8,
  parameter int NPAT = 5,
  parameter int CW   = 4
);
  localparam int IW = (NPAT > 1) ? $clog2(NPAT) : 1;

  // Table configuration
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [UW-1:0] cfg_val;
  logic [UW-1:0] cfg_care;
  logic [CW-1:0] cfg_code;
  logic          cfg_en;

  // Input stream
  logic          in_valid;
  logic          in_ready;
  logic [UW-1:0] in_data;

  // Output stream
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;
  logic          out_hit;
  logic          out_multi;

  modport master (
    output cfg_we, cfg_idx, cfg_val, cfg_care, cfg_code, cfg_en,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_code, out_hit, out_multi,
    output out_ready
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_val, cfg_care, cfg_code, cfg_en,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_code, out_hit, out_multi,
    input  out_ready
  );
endinterface

// File: rtl/casez_classifier.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// casez_classifier
// Classifies each accepted input word against a programmable table of
// value/care-mask entries (a run-time casez). The lowest-index enabled entry
// that matches supplies the class code; words matching no entry get DEF_CODE.
// Words matching two or more entries are flagged (out_multi) and counted in a
// saturating violation counter.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   bus        : casez_classifier_if.slave
//                  cfg_*   table write (takes effect the following cycle)
//                  in_*    valid/ready input stream
//                  out_*   valid/ready output stream, latency 1
//   viol_count : saturating count of accepted words with multiple matches
// -----------------------------------------------------------------------------
module casez_classifier #(
  parameter int            UW       = 8,
  parameter int            NPAT     = 5,
  parameter int            CW       = 4,
  parameter logic [CW-1:0] DEF_CODE = '1,
  parameter int            CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  casez_classifier_if.slave   bus,
  output logic [CNTW-1:0]     viol_count
);

  // One table entry; care bit 0 makes the corresponding data bit a wildcard.
  typedef struct packed {
    logic          en;
    logic [UW-1:0] val;
    logic [UW-1:0] care;
    logic [CW-1:0] code;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t          tbl_q [NPAT];
  entry_t          tbl_d [NPAT];

  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_code_q,  out_code_d;
  logic            out_hit_q,   out_hit_d;
  logic            out_multi_q, out_multi_d;
  logic [CNTW-1:0] viol_q,      viol_d;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic            cfg_ok;
  logic [NPAT-1:0] match;
  logic [CW-1:0]   cls_code;
  logic            cls_hit;
  logic            cls_multi;
  logic            in_ready;
  logic            accept;

  // Writes addressed beyond the last entry are dropped rather than aliased.
  assign cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < NPAT);

  // ---------------------------------------------------------------------------
  // Table next state. The classification below reads tbl_q, so a write in the
  // same cycle as a transfer only affects later words.
  // ---------------------------------------------------------------------------
  always_comb begin : table_next
    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    tbl_d = tbl_q;
    if (cfg_ok) begin
      tbl_d[bus.cfg_idx] = '{en:   bus.cfg_en,
                             val:  bus.cfg_val,
                             care: bus.cfg_care,
                             code: bus.cfg_code};
    end
  end

  // ---------------------------------------------------------------------------
  // Per-entry match: only the cared-for bits must agree.
  // ---------------------------------------------------------------------------
  always_comb begin : match_vec
    match = '0;
    for (int i = 0; i < NPAT; i++) begin
      match[i] = tbl_q[i].en &&
                 (((bus.in_data ^ tbl_q[i].val) & tbl_q[i].care) == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Priority pick. Scanning from the top index down means the last match seen
  // is the lowest index; any match found after a first one flags multi.
  // ---------------------------------------------------------------------------
  always_comb begin : priority_pick
    cls_code  = DEF_CODE;
    cls_hit   = 1'b0;
    cls_multi = 1'b0;
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (match[i]) begin
        if (cls_hit) begin
          cls_multi = 1'b1;
        end
        cls_hit  = 1'b1;
        cls_code = tbl_q[i].code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Single-stage output register with valid/ready. A new word can enter when
  // the stage is empty or is being drained this cycle, giving full throughput.
  // ---------------------------------------------------------------------------
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin : out_next
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_hit_d   = out_hit_q;
    out_multi_d = out_multi_q;
    viol_d      = viol_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_code_d  = cls_code;
      out_hit_d   = cls_hit;
      out_multi_d = cls_multi;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Counted at acceptance, saturating at all-ones.
    if (accept && cls_multi && (viol_q != '1)) begin
      viol_d = viol_q + CNTW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : regs
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (rst) begin
      // NOTE: the table is reset explicitly because a cleared table (all
      // entries disabled) is the defined post-reset behaviour; a plain RAM
      // without reset would leave stale entries matching.
      for (int i = 0; i < NPAT; i++) begin
        tbl_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_code_q  <= DEF_CODE;
      out_hit_q   <= 1'b0;
      out_multi_q <= 1'b0;
      viol_q      <= '0;
    end else begin
      tbl_q       <= tbl_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_hit_q   <= out_hit_d;
      out_multi_q <= out_multi_d;
      viol_q      <= viol_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_multi = out_multi_q;
  assign viol_count    = viol_q;

endmodule

// File: tb/tb_casez_classifier.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_casez_classifier
// Self-checking bench: directed vector tables, hand-written handshake/reset
// sequences and a randomized run, all compared against a behavioural model of
// the classification rules. A second instance with CNTW=2 exercises counter
// saturation.
// -----------------------------------------------------------------------------
module tb_casez_classifier;

  localparam int            UW   = 8;
  localparam int            NPAT = 5;
  localparam int            CW   = 4;
  localparam int            IW   = $clog2(NPAT);
  localparam int            CNTW = 16;
  localparam logic [CW-1:0] DEF  = '1;
  localparam int            VMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  casez_classifier_if #(.UW(UW), .NPAT(NPAT), .CW(CW)) bus  ();
  casez_classifier_if #(.UW(UW), .NPAT(NPAT), .CW(CW)) bus2 ();

  logic [CNTW-1:0] viol_count;
  logic [1:0]      viol2;

  casez_classifier #(.UW(UW), .NPAT(NPAT), .CW(CW), .DEF_CODE(DEF), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .viol_count(viol_count)
  );

  casez_classifier #(.UW(UW), .NPAT(NPAT), .CW(CW), .DEF_CODE(DEF), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .viol_count(viol2)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the dut instance
  // ---------------------------------------------------------------------------
  logic          m_en   [NPAT];
  logic [UW-1:0] m_val  [NPAT];
  logic [UW-1:0] m_care [NPAT];
  logic [CW-1:0] m_code [NPAT];
  logic          m_held;
  logic [CW-1:0] m_ocode;
  logic          m_ohit;
  logic          m_omulti;
  int            m_viol;

  // A word fits an entry when every bit the entry cares about agrees.
  function automatic bit fits(input logic [UW-1:0] d, input int i);
    if (!m_en[i]) return 1'b0;
    for (int b = 0; b < UW; b++) begin
      if (m_care[i][b] && (d[b] != m_val[i][b])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void classify(input logic [UW-1:0] d, output logic [CW-1:0] code,
                                   output logic hit, output logic multi);
    int hits[$];
    for (int i = 0; i < NPAT; i++) begin
      if (fits(d, i)) hits.push_back(i);
    end
    hit   = (hits.size() > 0);
    multi = (hits.size() > 1);
    code  = hit ? m_code[hits[0]] : DEF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPAT; i++) begin
      m_en[i] = 1'b0; m_val[i] = '0; m_care[i] = '0; m_code[i] = '0;
    end
    m_held = 1'b0; m_ocode = DEF; m_ohit = 1'b0; m_omulti = 1'b0; m_viol = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Drive helpers (inputs change #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_in(input logic v, input logic [UW-1:0] d, input logic rdy);
    bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
  endtask

  task automatic drive_cfg(input logic we, input logic [IW-1:0] idx, input logic [UW-1:0] val,
                           input logic [UW-1:0] care, input logic [CW-1:0] code, input logic en);
    bus.cfg_we = we; bus.cfg_idx = idx; bus.cfg_val = val;
    bus.cfg_care = care; bus.cfg_code = code; bus.cfg_en = en;
  endtask

  // One clock: predict, check in_ready, take the edge, update the model,
  // then check registered outputs #1 after the edge.
  task automatic cycle();
    logic [CW-1:0] c;
    logic          h, mu, exp_rdy, acc;
    #1;
    classify(bus.in_data, c, h, mu);
    exp_rdy = !m_held || bus.out_ready;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (acc) begin
        m_held = 1'b1; m_ocode = c; m_ohit = h; m_omulti = mu;
        if (mu && m_viol < VMAX) m_viol++;
      end else if (bus.out_ready) begin
        m_held = 1'b0;
      end
      if (bus.cfg_we && int'(bus.cfg_idx) < NPAT) begin
        m_en[bus.cfg_idx]   = bus.cfg_en;
        m_val[bus.cfg_idx]  = bus.cfg_val;
        m_care[bus.cfg_idx] = bus.cfg_care;
        m_code[bus.cfg_idx] = bus.cfg_code;
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_held));
    if (m_held) begin
      check("out_code",  32'(bus.out_code),  32'(m_ocode));
      check("out_hit",   32'(bus.out_hit),   32'(m_ohit));
      check("out_multi", 32'(bus.out_multi), 32'(m_omulti));
    end
    check("viol_count", 32'(viol_count), 32'(m_viol));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [UW-1:0] data;
    logic [CW-1:0] code;
    logic          hit;
    logic          multi;
  } vec_t;

  vec_t vec1 [7];
  vec_t vec2 [2];

  task automatic run_vec(input vec_t v);
    drive_in(1'b1, v.data, 1'b1);
    cycle();
    check($sformatf("vec_code_%02h", v.data),  32'(bus.out_code),  32'(v.code));
    check($sformatf("vec_hit_%02h", v.data),   32'(bus.out_hit),   32'(v.hit));
    check($sformatf("vec_multi_%02h", v.data), 32'(bus.out_multi), 32'(v.multi));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] exp2 [4];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3};

    // Table 1: e0 00/F0->1, e1 01/F1->2, e2 A0/FF->3, e3 80/80->4, e4 disabled
    vec1 = '{'{8'h01, 4'h1, 1'b1, 1'b1},
             '{8'h05, 4'h1, 1'b1, 1'b1},
             '{8'h12, 4'hF, 1'b0, 1'b0},
             '{8'hA0, 4'h3, 1'b1, 1'b1},
             '{8'h85, 4'h4, 1'b1, 1'b0},
             '{8'h0E, 4'h1, 1'b1, 1'b0},
             '{8'h11, 4'hF, 1'b0, 1'b0}};
    // Table 2: e4 enabled as a catch-all with code 5
    vec2 = '{'{8'h12, 4'h5, 1'b1, 1'b0},
             '{8'h85, 4'h4, 1'b1, 1'b1}};

    drive_in(1'b0, '0, 1'b0);
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
    bus2.cfg_we = 1'b0; bus2.cfg_idx = '0; bus2.cfg_val = '0; bus2.cfg_care = '0;
    bus2.cfg_code = '0; bus2.cfg_en = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = '0;
    bus2.out_ready = 1'b1;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_code",  32'(bus.out_code),  32'(DEF));
    check("rst_out_hit",   32'(bus.out_hit),   32'd0);
    check("rst_out_multi", 32'(bus.out_multi), 32'd0);
    check("rst_viol",      32'(viol_count),    32'd0);
    check("rst_viol2",     32'(viol2),         32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;

    // Empty table: default code, no hit
    drive_in(1'b1, 8'hA5, 1'b1);
    cycle();
    check("empty_valid", 32'(bus.out_valid), 32'd1);
    check("empty_code",  32'(bus.out_code),  32'hF);
    check("empty_hit",   32'(bus.out_hit),   32'd0);
    check("empty_multi", 32'(bus.out_multi), 32'd0);
    drive_in(1'b0, '0, 1'b1);

    // Program table 1; a write to idx 6 must be ignored
    drive_cfg(1'b1, 3'd0, 8'h00, 8'hF0, 4'h1, 1'b1); cycle();
    drive_cfg(1'b1, 3'd1, 8'h01, 8'hF1, 4'h2, 1'b1); cycle();
    drive_cfg(1'b1, 3'd2, 8'hA0, 8'hFF, 4'h3, 1'b1); cycle();
    drive_cfg(1'b1, 3'd3, 8'h80, 8'h80, 4'h4, 1'b1); cycle();
    drive_cfg(1'b1, 3'd4, 8'h55, 8'h00, 4'h5, 1'b0); cycle();
    drive_cfg(1'b1, 3'd6, 8'h11, 8'h00, 4'h9, 1'b1); cycle();
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vec1[i]);
      if (i == 0) check("viol_first_multi", 32'(viol_count), 32'd1);
    end
    check("viol_after_table1", 32'(viol_count), 32'd3);

    drive_in(1'b0, '0, 1'b1);
    drive_cfg(1'b1, 3'd4, 8'h55, 8'h00, 4'h5, 1'b1); cycle();
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 2; i++) run_vec(vec2[i]);

    // Backpressure: out_ready low for 3 cycles with in_valid high
    drive_in(1'b1, 8'h85, 1'b0);
    cycle();
    drive_in(1'b1, 8'h0E, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_code",     32'(bus.out_code), 32'h4);
    end
    // Release: back-to-back words keep order
    drive_in(1'b1, 8'h0E, 1'b1); cycle();
    check("order_0E", 32'(bus.out_code), 32'h1);
    drive_in(1'b1, 8'h12, 1'b1); cycle();
    check("order_12", 32'(bus.out_code), 32'h5);
    drive_in(1'b1, 8'hA0, 1'b1); cycle();
    check("order_A0", 32'(bus.out_code), 32'h3);
    drive_in(1'b0, '0, 1'b1); cycle();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Same-cycle table write uses the old code, next word sees the new one
    drive_in(1'b1, 8'h0E, 1'b1);
    drive_cfg(1'b1, 3'd0, 8'h00, 8'hF0, 4'h7, 1'b1);
    cycle();
    check("samecyc_old_code", 32'(bus.out_code), 32'h1);
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
    cycle();
    check("samecyc_new_code", 32'(bus.out_code), 32'h7);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [UW-1:0] d;
      int            e;
      e = $urandom_range(0, NPAT - 1);
      if ($urandom_range(0, 1) == 1) d = 8'($urandom);
      else d = m_val[e] ^ (8'($urandom) & ~m_care[e]);
      drive_in(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 9) == 0) begin
        drive_cfg(1'b1, 3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom & $urandom),
                  4'($urandom), ($urandom_range(0, 3) != 0));
      end else begin
        drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
      end
      cycle();
    end
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
    drive_in(1'b0, '0, 1'b1);

    // CNTW=2 instance: four multi-match words saturate at 3
    bus2.cfg_we = 1'b1; bus2.cfg_idx = 3'd0; bus2.cfg_care = 8'h00;
    bus2.cfg_code = 4'h1; bus2.cfg_en = 1'b1;
    cycle();
    bus2.cfg_idx = 3'd1; bus2.cfg_code = 4'h2;
    cycle();
    bus2.cfg_we = 1'b0;
    bus2.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus2.in_data = 8'($urandom);
      cycle();
      check($sformatf("sat_viol_%0d", k), 32'(viol2), 32'(exp2[k]));
      check($sformatf("sat_multi_%0d", k), 32'(bus2.out_multi), 32'd1);
    end
    bus2.in_valid = 1'b0;

    // Reset while an output is held; colliding cfg write and input ignored
    drive_cfg(1'b1, 3'd0, 8'h00, 8'hF0, 4'h1, 1'b1); cycle();
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
    drive_in(1'b1, 8'h01, 1'b0);
    cycle();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    drive_cfg(1'b1, 3'd1, 8'h00, 8'h00, 4'h3, 1'b1);
    cycle();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_viol",  32'(viol_count),    32'd0);
    check("midrst_code",  32'(bus.out_code),  32'(DEF));
    check("midrst_hit",   32'(bus.out_hit),   32'd0);
    check("midrst_viol2", 32'(viol2),         32'd0);
    rst = 1'b0;
    drive_cfg(1'b0, '0, '0, '0, '0, 1'b0);
    drive_in(1'b0, '0, 1'b0);
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    drive_in(1'b1, 8'h01, 1'b1);
    cycle();
    check("cleared_tbl_code", 32'(bus.out_code), 32'(DEF));
    check("cleared_tbl_hit",  32'(bus.out_hit),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/casez_classifier.md
CASEZ_CLASSIFIER -- requirements
Module: casez_classifier

Interface
REQ-001 Parameter UW, default 8: width of classified input word.
REQ-002 Parameter NPAT, default 5: number of programmable pattern entries (>=2).
REQ-003 Parameter CW, default 4: width of class code.
REQ-004 Parameter DEF_CODE, default all-ones: code returned when no entry matches.
REQ-005 Parameter CNTW, default 16: width of violation counter.
REQ-006 Port clk  in  1: sole clock; all state updates on rising edge.
REQ-007 Port rst  in  1: reset, synchronous, active-high.
REQ-008 Port cfg_we  in  1: table write strobe.
REQ-009 Port cfg_idx  in  clog2(NPAT): entry to write.
REQ-010 Port cfg_val / cfg_care  in  UW each: match value; care mask (0 = wildcard bit).
REQ-011 Port cfg_code  in  CW: class code of entry.
REQ-012 Port cfg_en  in  1: entry enable.
REQ-013 Port in_valid / in_ready  in / out  1: input handshake.
REQ-014 Port in_data  in  UW: word to classify.
REQ-015 Port out_valid / out_ready  out / in  1: output handshake.
REQ-016 Port out_code  out  CW: class result.
REQ-017 Port out_hit / out_multi  out  1: >=1 enabled entry matched; >=2 matched (uniqueness violation).
REQ-018 Port viol_count  out  CNTW: saturating count of accepted words with out_multi set.

Function
REQ-019 Entry i matches when enabled and ((in_data XOR val_i) AND care_i) == 0; all-zero care matches every word.
REQ-020 Priority: lowest matching index supplies out_code; no match -> out_code = DEF_CODE, out_hit = 0.
REQ-021 out_multi = 1 iff two or more enabled entries match, regardless of codes.
REQ-022 Transfer occurs when in_valid && in_ready; result registered, out_valid high the next cycle (latency 1).
REQ-023 in_ready = !out_valid || out_ready; back-to-back transfers sustain one word per cycle.
REQ-024 While out_valid && !out_ready, out_code/out_hit/out_multi hold stable; no word dropped or duplicated.
REQ-025 out_valid clears after an output transfer with no simultaneous input transfer.
REQ-026 cfg write to cfg_idx >= NPAT ignored.
REQ-027 Table write takes effect the cycle after cfg_we; same-cycle classification uses old table contents.
REQ-028 Table writes never alter an already-registered output result.
REQ-029 viol_count increments on the cycle a word with multiple matches is accepted at input; saturates at 2^CNTW-1, no wrap.

Reset
REQ-030 rst clears all entry enables, val/care/code to 0, out_valid to 0, out_code to DEF_CODE, out_hit/out_multi to 0, viol_count to 0.
REQ-031 rst asserted mid-stream discards the held output; in_ready = 1 the cycle after rst deasserts.
REQ-032 rst has priority over cfg_we and in_valid in the same cycle.

Verification
REQ-033 After reset, in_data=8'hA5 -> out_valid next cycle, out_code=4'hF, out_hit=0, out_multi=0.
REQ-034 Entry0 val=8'h00 care=8'hF0 code=1, entry1 val=8'h01 care=8'hF1 code=2; in=8'h01 -> code=1, hit=1, multi=1, viol_count=1.
REQ-035 out_ready held low 3 cycles with in_valid high -> in_ready=0, output stable; out_ready=1 -> one transfer per cycle, order preserved.
REQ-036 cfg_we rewriting entry0 code to 7 in same cycle as input match -> that word gets old code 1; next word gets 7.
REQ-037 CNTW=2, four multi-match words -> viol_count 1,2,3,3.
REQ-038 rst asserted while out_valid=1 and out_ready=0 -> out_valid=0, table cleared, viol_count=0 next cycle.
